bitcol_encoder: RTL
===================

BITCOL_ENCODER -- requirements
Module: bitcol_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: weight bit width and number of bit columns per weight vector.
REQ-002 Parameter VEC_LENGTH, default 16: weights per vector, split into VEC_LENGTH/8 groups of 8.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-005 Port w_valid, input, 1: weight vector valid.
REQ-006 Port w_ready, output, 1: encoder can accept a weight vector.
REQ-007 Port weight, input, [DATA_WIDTH-1:0] x VEC_LENGTH unpacked: signed weights.
REQ-008 Port col_valid, output, 1: column control word valid.
REQ-009 Port col_ready, input, 1: MAC consumes the word; col_valid && col_ready drives the MAC en.
REQ-010 Port act_sel, output, [3:0] x VEC_LENGTH/2: activation select per adder slot; values 0..7 index within the group; 8 selects zero.
REQ-011 Port is_skip_zero, output, 1 x VEC_LENGTH/8: 1 means the slots select ones-positions; 0 means zero-positions (MAC subtracts from sum_act).
REQ-012 Port is_msb, output, 1: current column is bit DATA_WIDTH-1.
REQ-013 Port column_idx, output, [2:0]: bit index of current column.
REQ-014 Port col_last, output, 1: current column is bit 0.

Function
REQ-015 States IDLE and STREAM; reset enters IDLE.
REQ-016 w_ready SHALL be 1 in IDLE, and in STREAM only while col_last && col_valid && col_ready (back-to-back vectors).
REQ-017 On w_valid && w_ready, weights SHALL be latched and the next cycle SHALL present column DATA_WIDTH-1 with col_valid=1 (one-cycle latency).
REQ-018 Columns SHALL be issued MSB first, DATA_WIDTH-1 down to 0, one per output handshake, none skipped.
REQ-019 While col_valid && !col_ready, all outputs SHALL hold stable.
REQ-020 Per group g, per column: ones = popcount of bit column; if ones <= 4, is_skip_zero[g]=1 and slots list ones-positions; else is_skip_zero[g]=0 and slots list zero-positions.
REQ-021 Listed positions SHALL fill slots 4g..4g+3 in ascending position order; unfilled slots SHALL be 8.
REQ-022 is_msb=1 only for column DATA_WIDTH-1; col_last=1 only for column 0.
REQ-023 After column 0 handshake with no new vector accepted, col_valid SHALL drop and the state SHALL return to IDLE.
REQ-024 w_valid in STREAM outside the REQ-016 window SHALL be ignored (not latched).

Reset
REQ-025 During reset: col_valid=0, w_ready=0, act_sel all 8, is_skip_zero all 1, is_msb=0, column_idx=0, col_last=0.
REQ-026 Reset mid-stream SHALL abandon the vector; the first cycle after release SHALL be IDLE with w_ready=1.

Configuration
REQ-027 Macro BITCOL_ENCODER_PERF_EN: when defined, add outputs perf_cols [31:0] (columns handshaken) and perf_inv [31:0] (group-columns with is_skip_zero=0), saturating, reset to 0; when undefined, these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-028 Shared package bitsim_pkg SHALL hold GROUP_SIZE=8, SLOTS_PER_GROUP=4, SEL_NULL=4'd8, and the state enum typedef.
REQ-029 One sub-module bitcol_group_enc SHALL map an 8-bit column to 4 selects plus is_skip_zero, instantiated VEC_LENGTH/8 times.

Verification
REQ-030 All weights 0, col_ready=1 -> 8 columns, all act_sel=8, is_skip_zero=1, is_msb only on first, col_last only on eighth.
REQ-031 Group 0 weights all -1 (8'hFF) -> every column is_skip_zero[0]=0, act_sel[0..3]=8.
REQ-032 Group 0 weights {1,0,1,0,1,0,0,0} (index 0..7) -> column 0 selects 0,2,4,8, is_skip_zero=1; columns 7..1 all 8.
REQ-033 Group 0 weights {1,1,1,1,1,0,1,0} -> column 0 is_skip_zero=0, selects 5,7,8,8.
REQ-034 col_ready toggling 1/0 per cycle -> outputs stable while stalled, 8 columns in 16 cycles; second vector with w_valid held accepted on column-0 handshake, its MSB column following with no bubble.
REQ-035 Reset asserted at column 4 -> outputs at reset values immediately; after release w_ready=1, next vector starts at column 7.

Source files
------------

// File: rtl/bitsim_pkg.sv
// Shared constants and state type for the bit-column weight encoder.
package bitsim_pkg;
  localparam int         GROUP_SIZE      = 8;
  localparam int         SLOTS_PER_GROUP = 4;
  localparam logic [3:0] SEL_NULL        = 4'd8;

  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/bitcol_group_enc.sv
// Maps one 8-bit weight column to four adder-slot selects plus the skip-zero flag.
module bitcol_group_enc
  import bitsim_pkg::*;
(
  input  logic [GROUP_SIZE-1:0]           col_i,
  output logic [SLOTS_PER_GROUP-1:0][3:0] sel_o,
  output logic                            skip_zero_o
);
  logic [3:0]            ones;
  logic [GROUP_SIZE-1:0] pick;
  logic [2:0]            n;

  // The minority bit value always fits in four slots, so list it.
  always_comb begin
    ones = '0;
    for (int i = 0; i < GROUP_SIZE; i++) ones = ones + {3'b0, col_i[i]};
    skip_zero_o = (ones <= 4'd4);
    pick        = skip_zero_o ? col_i : ~col_i;
    sel_o       = {SLOTS_PER_GROUP{SEL_NULL}};
    n           = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (pick[i] && (n < 3'd4)) begin
        sel_o[n[1:0]] = 4'(i);
        n             = n + 3'd1;
      end
    end
  end
endmodule

// File: rtl/bitcol_encoder.sv
// Streams a latched weight vector as MSB-first bit columns of adder-slot selects.
// Optional perf counters are built when BITCOL_ENCODER_PERF_EN is defined.
module bitcol_encoder
  import bitsim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] weight [VEC_LENGTH],
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic [3:0]            act_sel [VEC_LENGTH/2],
  output logic [VEC_LENGTH/8-1:0] is_skip_zero,
  output logic                  is_msb,
  output logic [2:0]            column_idx,
  output logic                  col_last
`ifdef BITCOL_ENCODER_PERF_EN
  ,
  output logic [31:0]           perf_cols,
  output logic [31:0]           perf_inv
`endif
);
  localparam int         NGRP    = VEC_LENGTH / GROUP_SIZE;
  localparam logic [2:0] MSB_COL = 3'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [2:0]            col_q, col_d;
  logic [DATA_WIDTH-1:0] w_q [VEC_LENGTH];
  logic                  hs, accept;

  assign col_valid  = (state_q == STREAM);
  assign hs         = col_valid && col_ready;
  assign accept     = w_valid && w_ready;
  assign column_idx = col_q;
  assign is_msb     = col_valid && (col_q == MSB_COL);
  assign col_last   = col_valid && (col_q == 3'd0);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    w_ready = 1'b0;
    case (state_q)
      IDLE:    w_ready = 1'b1;
      STREAM:  w_ready = (col_q == 3'd0) && col_ready;
      default: w_ready = 1'b0;
    endcase
    if (reset) w_ready = 1'b0;
    if (accept) begin
      state_d = STREAM;
      col_d   = MSB_COL;
    end else if (hs) begin
      if (col_q == 3'd0) state_d = IDLE;
      else               col_d   = col_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      for (int i = 0; i < VEC_LENGTH; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (accept)
        for (int i = 0; i < VEC_LENGTH; i++) w_q[i] <= weight[i];
    end
  end

  // Columns are gated by col_valid so idle/reset cycles present null selects.
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [GROUP_SIZE-1:0]           colbits;
    logic [SLOTS_PER_GROUP-1:0][3:0] sel;

    always_comb begin
      colbits = '0;
      for (int i = 0; i < GROUP_SIZE; i++)
        colbits[i] = w_q[g*GROUP_SIZE+i][col_q] & col_valid;
    end

    bitcol_group_enc u_enc (
      .col_i       (colbits),
      .sel_o       (sel),
      .skip_zero_o (is_skip_zero[g])
    );

    for (genvar s = 0; s < SLOTS_PER_GROUP; s++) begin : g_slot
      assign act_sel[g*SLOTS_PER_GROUP+s] = sel[s];
    end
  end

`ifdef BITCOL_ENCODER_PERF_EN
  logic [31:0] perf_cols_q, perf_inv_q;
  logic [31:0] inv_cnt;
  logic [32:0] inv_sum;

  always_comb begin
    inv_cnt = '0;
    for (int g = 0; g < NGRP; g++) inv_cnt = inv_cnt + {31'b0, ~is_skip_zero[g]};
    inv_sum = {1'b0, perf_inv_q} + {1'b0, inv_cnt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cols_q <= '0;
      perf_inv_q  <= '0;
    end else if (hs) begin
      if (perf_cols_q != '1) perf_cols_q <= perf_cols_q + 32'd1;
      perf_inv_q <= inv_sum[32] ? '1 : inv_sum[31:0];
    end
  end

  assign perf_cols = perf_cols_q;
  assign perf_inv  = perf_inv_q;
`endif
endmodule
